// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle: instruction-memory read port, redirect input and the
// decoupled {pc, instr} output stream towards IF/ID.
interface if_prefetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [29:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [29:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [29:0]   out_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    output imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues 1-cycle-latency imem
// reads under a credit limit and buffers {pc, instr} so decode stalls don't stall fetch.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic               clk,
  input  logic               rst,
  if_prefetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [29:0]   fpc_q, fpc_d;
  logic [29:0]   ipc_q, ipc_d;
  logic          infl_q, infl_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW+1:0] reserved;
  logic          issue, push, pop;

  always_comb begin
    // Buffered plus in-flight slots; issuing only below DEPTH makes overflow impossible.
    reserved = {1'b0, cnt_q} + {{(AW+1){1'b0}}, infl_q};
    issue    = !rst && !bus.redirect && (reserved < DEPTH_W);
    push     = infl_q && !bus.redirect;
    pop      = (cnt_q != '0) && bus.out_ready && !bus.redirect;

    fpc_d  = fpc_q;
    ipc_d  = ipc_q;
    infl_d = infl_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;

    if (bus.redirect) begin
      fpc_d  = bus.redirect_pc;
      infl_d = 1'b0;
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
    end else begin
      infl_d = issue;
      if (issue) begin
        fpc_d = fpc_q + 30'd1;
        ipc_d = fpc_q;
      end
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q  <= RESET_PC;
      ipc_q  <= RESET_PC;
      infl_q <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      fpc_q  <= fpc_d;
      ipc_q  <= ipc_d;
      infl_q <= infl_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= '{pc: ipc_q, instr: bus.imem_rdata};
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fpc_q;
  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_instr = fifo_q[rd_q].instr;
  assign bus.out_pc    = fifo_q[rd_q].pc;
  assign bus.count     = cnt_q;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: hand-derived vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [29:0] RST_PC = 30'h0000_0C00;

  logic clk, rst;
  int   n_chk = 0;
  int   n_fail = 0;

  if_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: mem[a] = a, one-cycle latency; garbage when not requested.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= {2'b00, bus.imem_addr};
    else              bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  // Reference model: buffered PCs, PCs in flight, next fetch address.
  logic [29:0] mq[$];
  logic [29:0] pend[$];
  logic [29:0] mfpc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    mq.delete();
    pend.delete();
    mfpc = RST_PC;
  endtask

  // Called mid-cycle (negedge): drive, check against model, advance model, wait one cycle.
  task automatic step(input logic rd, input logic [29:0] rpc, input logic rdy);
    logic        exp_req;
    logic        ret;
    logic [29:0] np;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.out_ready   = rdy;
    #1;
    exp_req = !rd && ((mq.size() + pend.size()) < DEPTH);
    chk("req",   64'(bus.imem_req),  64'(exp_req));
    chk("addr",  64'(bus.imem_addr), 64'(mfpc));
    chk("valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("count", 64'(bus.count),     64'(mq.size()));
    if (mq.size() != 0) begin
      chk("out_pc",    64'(bus.out_pc),    64'(mq[0]));
      chk("out_instr", 64'(bus.out_instr), 64'({2'b00, mq[0]}));
    end
    if (rd) begin
      mq.delete();
      pend.delete();
      mfpc = rpc;
    end else begin
      ret = (pend.size() != 0);
      np  = '0;
      if (ret) np = pend.pop_front();
      if (exp_req) begin
        pend.push_back(mfpc);
        mfpc = mfpc + 30'd1;
      end
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (ret) mq.push_back(np);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({nm, "_count"}, 64'(bus.count),     64'(0));
    chk({nm, "_req"},   64'(bus.imem_req),  64'(0));
  endtask

  typedef struct {
    logic        rd;
    logic [29:0] rpc;
    logic        rdy;
    logic        req;
    logic [29:0] addr;
    logic        vld;
    logic [29:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // Cycle k = interval ending at rising edge k after reset release.
    tbl[0]  = '{1'b0, 30'h0,   1'b1, 1'b1, 30'hC00, 1'b0, 30'h0,   3'd0};
    tbl[1]  = '{1'b0, 30'h0,   1'b1, 1'b1, 30'hC01, 1'b0, 30'h0,   3'd0};
    tbl[2]  = '{1'b0, 30'h0,   1'b1, 1'b1, 30'hC02, 1'b1, 30'hC00, 3'd1};
    tbl[3]  = '{1'b0, 30'h0,   1'b1, 1'b1, 30'hC03, 1'b1, 30'hC01, 3'd1};
    tbl[4]  = '{1'b0, 30'h0,   1'b0, 1'b1, 30'hC04, 1'b1, 30'hC02, 3'd1};
    tbl[5]  = '{1'b0, 30'h0,   1'b0, 1'b1, 30'hC05, 1'b1, 30'hC02, 3'd2};
    tbl[6]  = '{1'b0, 30'h0,   1'b0, 1'b0, 30'hC06, 1'b1, 30'hC02, 3'd3};
    tbl[7]  = '{1'b0, 30'h0,   1'b0, 1'b0, 30'hC06, 1'b1, 30'hC02, 3'd4};
    tbl[8]  = '{1'b0, 30'h0,   1'b0, 1'b0, 30'hC06, 1'b1, 30'hC02, 3'd4};
    tbl[9]  = '{1'b0, 30'h0,   1'b1, 1'b0, 30'hC06, 1'b1, 30'hC02, 3'd4};
    tbl[10] = '{1'b0, 30'h0,   1'b1, 1'b1, 30'hC06, 1'b1, 30'hC03, 3'd3};
    tbl[11] = '{1'b0, 30'h0,   1'b1, 1'b1, 30'hC07, 1'b1, 30'hC04, 3'd2};
    tbl[12] = '{1'b0, 30'h0,   1'b1, 1'b1, 30'hC08, 1'b1, 30'hC05, 3'd2};
    tbl[13] = '{1'b0, 30'h0,   1'b1, 1'b1, 30'hC09, 1'b1, 30'hC06, 3'd2};
    tbl[14] = '{1'b1, 30'h100, 1'b1, 1'b0, 30'hC0A, 1'b1, 30'hC07, 3'd2};
    tbl[15] = '{1'b0, 30'h0,   1'b1, 1'b1, 30'h100, 1'b0, 30'h0,   3'd0};
    tbl[16] = '{1'b0, 30'h0,   1'b1, 1'b1, 30'h101, 1'b0, 30'h0,   3'd0};
    tbl[17] = '{1'b0, 30'h0,   1'b1, 1'b1, 30'h102, 1'b1, 30'h100, 3'd1};

    rst = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    chk("rst_addr", 64'(bus.imem_addr), 64'(RST_PC));
    rst = 1'b0;

    // Vector table: first fetch, stall to full, resume, redirect.
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      bus.redirect    = tbl[i].rd;
      bus.redirect_pc = tbl[i].rpc;
      bus.out_ready   = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_req", i),   64'(bus.imem_req),  64'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i),  64'(bus.imem_addr), 64'(tbl[i].addr));
      chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_count", i), 64'(bus.count),     64'(tbl[i].cnt));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i),    64'(bus.out_pc),    64'(tbl[i].pc));
        chk($sformatf("tbl%0d_instr", i), 64'(bus.out_instr), 64'({2'b00, tbl[i].pc}));
      end
    end

    @(negedge clk);
    bus.redirect  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outs("rst2");
    @(negedge clk);
    rst = 1'b0;
    mreset();

    // Redirect while count = 3 with a fetch in flight.
    repeat (4) step(1'b0, '0, 1'b0);
    chk("pre_redir_count", 64'(bus.count), 64'(3));
    step(1'b1, 30'h100, 1'b0);
    chk("post_redir_count", 64'(bus.count),     64'(0));
    chk("post_redir_valid", 64'(bus.out_valid), 64'(0));
    repeat (8) step(1'b0, '0, 1'b1);

    // Fill to DEPTH, then toggle ready so both pointers wrap repeatedly.
    repeat (8) step(1'b0, '0, 1'b0);
    chk("full_count", 64'(bus.count),    64'(DEPTH));
    chk("full_req",   64'(bus.imem_req), 64'(0));
    for (int i = 0; i < 24; i++) step(1'b0, '0, 1'(i % 2 == 0));

    // Randomized traffic, including redirects close to the 30-bit wrap.
    for (int i = 0; i < 1500; i++) begin
      logic        rd;
      logic [29:0] rpc;
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      step(rd, rpc, ($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset between edges.
    repeat (3) step(1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("async_rst");
    chk("async_rst_addr", 64'(bus.imem_addr), 64'(RST_PC));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mreset();
    repeat (6) step(1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word-address reads to the instruction memory, which has fixed 1-cycle read latency. Returned instructions and their PCs are buffered in a small FIFO, so decode stalls (load-use hazard, branch bubble) do not stall fetch. Branch and jump redirects flush all buffered and in-flight fetches.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- RESET_PC, 30'h0000_0C00: word address of the first fetch (byte address 0x3000)
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- imem_req  output  1  read request to instruction memory this cycle
- imem_addr  output  30  word address of the request (PC[31:2])
- imem_rdata  input  32  instruction; valid the cycle after imem_req
- redirect  input  1  taken branch/jump from ID; flush and refetch
- redirect_pc  input  30  new fetch word address
- out_valid  output  1  head entry valid
- out_ready  input  1  IF/ID accepts head; low on hazard or branch bubble
- out_instr  output  32  head instruction
- out_pc  output  30  head word address (PC[31:2])
- count  output  log2(DEPTH)+1  occupied entries

## Operation
- State: fpc (30b), inflight (1b), inflight_pc (30b), FIFO storage {pc, instr} × DEPTH, rd_ptr/wr_ptr (log2 DEPTH bits, wrap mod DEPTH), count.
- Issue: imem_req = !redirect && (count + inflight < DEPTH); imem_addr = fpc. On issue: fpc <= fpc + 1 (30-bit wrap), inflight <= 1, inflight_pc <= fpc; otherwise inflight <= 0.
- Return: when inflight = 1 and no redirect, {inflight_pc, imem_rdata} written at wr_ptr; wr_ptr++, count++.
- Pop: out_valid && out_ready -> rd_ptr++, count--. Push and pop in the same cycle leave count unchanged.
- out_valid = (count != 0); out_instr/out_pc read from rd_ptr (combinational from storage); undefined content when out_valid = 0.
- Credit rule guarantees no overflow: reserved slots (count + inflight) never exceed DEPTH. Pop with out_valid = 0 is ignored.
- Redirect (priority over everything): fpc <= redirect_pc; count, rd_ptr, wr_ptr <= 0; inflight <= 0; imem_rdata returning that cycle is discarded; pop that cycle ignored; imem_req = 0 that cycle.
- Reset: fpc = RESET_PC, count = 0, pointers = 0, inflight = 0; outputs out_valid = 0, count = 0, imem_req = 0 while rst high, imem_addr = RESET_PC. Reset mid-operation discards all buffered and in-flight data.

## Timing
- Fetch-to-output latency 2 cycles: req at cycle t, rdata at t+1, out_valid for that entry at t+2.
- First fetch: rst deasserted before edge 0 -> imem_req = 1 with addr RESET_PC in cycle 0; out_valid at cycle 2.
- Steady state with out_ready = 1: one instruction per cycle, count = 1, inflight = 1.
- Redirect asserted in cycle r: cycle r+1 req at redirect_pc; out_valid with out_pc = redirect_pc at r+3.
- With out_ready = 0: fetching continues until count = DEPTH, inflight = 0; imem_req stays low until a pop. Resumption: pop in cycle p -> req in p+1.
- All state updates on rising clk; rst acts immediately, independent of clk.

## Test plan
- Reset then out_ready = 1, imem returns mem[a] = a: out_pc 0xC00, 0xC01, 0xC02… on consecutive cycles from cycle 2, out_instr matching.
- Hold out_ready = 0 for 10 cycles: count saturates at 4, imem_req drops, no entry lost or duplicated; release -> PCs continue contiguously, one per cycle.
- Redirect to 0x100 while count = 3 and inflight = 1: next cycle count = 0, out_valid = 0; next out_pc = 0x100, no pre-redirect PC ever appears.
- Redirect in same cycle as out_ready = 1 and returning rdata: neither pop nor push takes effect; count = 0 next cycle.
- Full boundary: count = 4, pop, then keep out_ready toggling 1/0: count never exceeds 4, order preserved across wr_ptr/rd_ptr wrap.
- Assert rst asynchronously mid-stream (between edges): out_valid, count, imem_req go 0 immediately; after release fetch restarts at 0xC00.
